// File: rtl/dmux_chan_buf.sv
// Buffered 1-to-2 stream demux: per-channel FIFOs with independent drains.
// Optional DMUX_CHAN_BUF_STATS_EN adds per-channel accept counters and a stall flag.
module dmux_chan_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             y0_valid,
    output logic [WIDTH-1:0] y0_data,
    input  logic             y0_ready,
    output logic [CW-1:0]    y0_count,
    output logic             y1_valid,
    output logic [WIDTH-1:0] y1_data,
    input  logic             y1_ready,
    output logic [CW-1:0]    y1_count
`ifdef DMUX_CHAN_BUF_STATS_EN
    ,
    output logic [15:0]      acc0_cnt,
    output logic [15:0]      acc1_cnt,
    output logic             stall
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem0_q [DEPTH];
    logic [WIDTH-1:0] mem1_q [DEPTH];
    logic [AW-1:0]    wptr0_q, wptr0_d;
    logic [AW-1:0]    rptr0_q, rptr0_d;
    logic [AW-1:0]    wptr1_q, wptr1_d;
    logic [AW-1:0]    rptr1_q, rptr1_d;
    logic [CW-1:0]    cnt0_q, cnt0_d;
    logic [CW-1:0]    cnt1_q, cnt1_d;

    logic full0, full1;
    logic push0, push1;
    logic pop0, pop1;

    assign full0 = (cnt0_q == CW'(DEPTH));
    assign full1 = (cnt1_q == CW'(DEPTH));

    assign in_ready = in_sel ? ~full1 : ~full0;

    assign push0 = in_valid & in_ready & ~in_sel;
    assign push1 = in_valid & in_ready & in_sel;

    assign y0_valid = (cnt0_q != '0);
    assign y1_valid = (cnt1_q != '0);

    assign pop0 = y0_valid & y0_ready;
    assign pop1 = y1_valid & y1_ready;

    // Stale words stay in the array after a pop, so gate the head on occupancy.
    assign y0_data = y0_valid ? mem0_q[rptr0_q] : '0;
    assign y1_data = y1_valid ? mem1_q[rptr1_q] : '0;

    assign y0_count = cnt0_q;
    assign y1_count = cnt1_q;

    always_comb begin
        wptr0_d = wptr0_q;
        rptr0_d = rptr0_q;
        cnt0_d  = cnt0_q;
        if (push0) begin
            wptr0_d = wptr0_q + AW'(1);
        end
        if (pop0) begin
            rptr0_d = rptr0_q + AW'(1);
        end
        unique case ({push0, pop0})
            2'b10:   cnt0_d = cnt0_q + CW'(1);
            2'b01:   cnt0_d = cnt0_q - CW'(1);
            default: cnt0_d = cnt0_q;
        endcase
    end

    always_comb begin
        wptr1_d = wptr1_q;
        rptr1_d = rptr1_q;
        cnt1_d  = cnt1_q;
        if (push1) begin
            wptr1_d = wptr1_q + AW'(1);
        end
        if (pop1) begin
            rptr1_d = rptr1_q + AW'(1);
        end
        unique case ({push1, pop1})
            2'b10:   cnt1_d = cnt1_q + CW'(1);
            2'b01:   cnt1_d = cnt1_q - CW'(1);
            default: cnt1_d = cnt1_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr0_q <= '0;
            rptr0_q <= '0;
            cnt0_q  <= '0;
            wptr1_q <= '0;
            rptr1_q <= '0;
            cnt1_q  <= '0;
        end else begin
            wptr0_q <= wptr0_d;
            rptr0_q <= rptr0_d;
            cnt0_q  <= cnt0_d;
            wptr1_q <= wptr1_d;
            rptr1_q <= rptr1_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem0_q[i] <= '0;
                mem1_q[i] <= '0;
            end
        end else begin
            if (push0) begin
                mem0_q[wptr0_q] <= in_data;
            end
            if (push1) begin
                mem1_q[wptr1_q] <= in_data;
            end
        end
    end

`ifdef DMUX_CHAN_BUF_STATS_EN
    logic [15:0] acc0_q, acc0_d;
    logic [15:0] acc1_q, acc1_d;
    logic        stall_q, stall_d;

    always_comb begin
        acc0_d  = push0 ? acc0_q + 16'd1 : acc0_q;
        acc1_d  = push1 ? acc1_q + 16'd1 : acc1_q;
        stall_d = in_valid & ~in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc0_q  <= '0;
            acc1_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            acc0_q  <= acc0_d;
            acc1_q  <= acc1_d;
            stall_q <= stall_d;
        end
    end

    assign acc0_cnt = acc0_q;
    assign acc1_cnt = acc1_q;
    assign stall    = stall_q;
`endif

endmodule

// File: tb/tb_dmux_chan_buf.sv
// Randomised bench for dmux_chan_buf against a queue-based channel model.
// Also exercises the optional DMUX_CHAN_BUF_STATS_EN outputs when defined.
module tb_dmux_chan_buf;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_sel = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          y0_valid, y1_valid;
    logic [W-1:0]  y0_data, y1_data;
    logic          y0_ready = 1'b0;
    logic          y1_ready = 1'b0;
    logic [CW-1:0] y0_count, y1_count;
`ifdef DMUX_CHAN_BUF_STATS_EN
    logic [15:0]   acc0_cnt, acc1_cnt;
    logic          stall;
`endif

    dmux_chan_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .in_ready (in_ready),
        .y0_valid (y0_valid),
        .y0_data  (y0_data),
        .y0_ready (y0_ready),
        .y0_count (y0_count),
        .y1_valid (y1_valid),
        .y1_data  (y1_data),
        .y1_ready (y1_ready),
        .y1_count (y1_count)
`ifdef DMUX_CHAN_BUF_STATS_EN
        ,
        .acc0_cnt (acc0_cnt),
        .acc1_cnt (acc1_cnt),
        .stall    (stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] seen0[$];
    logic [W-1:0] seen1[$];
    int           m_acc0 = 0;
    int           m_acc1 = 0;
    logic         m_stall = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready();
        return in_sel ? (q1.size() < D) : (q0.size() < D);
    endfunction

    task automatic cmp();
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        chk("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
        chk("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
        chk("y0_count", 32'(y0_count), 32'(q0.size()));
        chk("y1_count", 32'(y1_count), 32'(q1.size()));
        chk("y0_data", 32'(y0_data), (q0.size() != 0) ? 32'(q0[0]) : 32'd0);
        chk("y1_data", 32'(y1_data), (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
`ifdef DMUX_CHAN_BUF_STATS_EN
        chk("acc0_cnt", 32'(acc0_cnt), 32'(m_acc0 % 65536));
        chk("acc1_cnt", 32'(acc1_cnt), 32'(m_acc1 % 65536));
        chk("stall", 32'(stall), 32'(m_stall));
`endif
    endtask

    // One clock: compare at negedge, advance the model at posedge.
    task automatic step();
        logic rdy, acc, p0, p1;
        @(negedge clk);
        cmp();
        rdy = model_ready();
        acc = in_valid && rdy;
        p0  = y0_ready && (q0.size() != 0);
        p1  = y1_ready && (q1.size() != 0);
        if (p0) seen0.push_back(y0_data);
        if (p1) seen1.push_back(y1_data);
        @(posedge clk);
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
        if (acc) begin
            if (in_sel) begin
                q1.push_back(in_data);
                m_acc1++;
            end else begin
                q0.push_back(in_data);
                m_acc0++;
            end
        end
        m_stall = in_valid && !rdy;
        #1;
    endtask

    task automatic drive(logic v, logic s, logic [W-1:0] d);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m_acc0  = 0;
        m_acc1  = 0;
        m_stall = 1'b0;
    endtask

    initial begin
        logic hold;
        #12;
        chk("rst_y0_valid", 32'(y0_valid), 32'd0);
        chk("rst_y1_valid", 32'(y1_valid), 32'd0);
        chk("rst_y0_data", 32'(y0_data), 32'd0);
        chk("rst_y1_count", 32'(y1_count), 32'd0);
        chk("rst_in_ready_s0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        #1;
        chk("rst_in_ready_s1", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1'b1, 1'b0, 8'hA5);
        step();
        drive(1'b0, 1'b0, 8'h00);
        chk("a5_y0_valid", 32'(y0_valid), 32'd1);
        chk("a5_y0_data", 32'(y0_data), 32'hA5);
        chk("a5_y0_count", 32'(y0_count), 32'd1);
        chk("a5_y1_valid", 32'(y1_valid), 32'd0);
        chk("a5_y1_count", 32'(y1_count), 32'd0);

        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b1, 8'(i));
            step();
        end
        chk("fill_y1_count", 32'(y1_count), 32'd4);
        drive(1'b1, 1'b1, 8'h05);
        #1;
        chk("full_rdy_s1", 32'(in_ready), 32'd0);
        in_sel = 1'b0;
        #1;
        chk("full_rdy_s0", 32'(in_ready), 32'd1);
        in_sel = 1'b1;
        step();
        step();
        chk("held_y1_count", 32'(y1_count), 32'd4);
        drive(1'b0, 1'b0, 8'h00);

        seen1.delete();
        y1_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        y1_ready = 1'b0;
        chk("drain_n", 32'(seen1.size()), 32'd4);
        for (int i = 0; i < 4 && i < seen1.size(); i++)
            chk("drain_seq", 32'(seen1[i]), 32'(i + 1));
        chk("drain_y1_valid", 32'(y1_valid), 32'd0);
        chk("drain_y1_count", 32'(y1_count), 32'd0);

        drive(1'b1, 1'b0, 8'h11);
        step();
        chk("two_y0_count", 32'(y0_count), 32'd2);
        drive(1'b1, 1'b0, 8'h22);
        y0_ready = 1'b1;
        step();
        drive(1'b0, 1'b0, 8'h00);
        y0_ready = 1'b0;
        chk("pp_y0_count", 32'(y0_count), 32'd2);
        chk("pp_y0_head", 32'(y0_data), 32'h11);

        y0_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        seen0.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'(i % 2), 8'((i + 1) * 16));
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        step();
        y0_ready = 1'b0;
        chk("il_y0_n", 32'(seen0.size()), 32'd2);
        if (seen0.size() == 2) begin
            chk("il_y0_a", 32'(seen0[0]), 32'h10);
            chk("il_y0_b", 32'(seen0[1]), 32'h30);
        end
        chk("il_y1_count", 32'(y1_count), 32'd2);
        chk("il_y1_head", 32'(y1_data), 32'h20);

        hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                drive($urandom_range(0, 9) < 7, 1'($urandom), 8'($urandom));
            end
            y0_ready = ($urandom_range(0, 9) < (n < 1500 ? 3 : 7));
            y1_ready = ($urandom_range(0, 9) < (n < 1500 ? 6 : 2));
            #1;
            hold = in_valid && !model_ready();
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        step();

        for (int i = 0; i < D; i++) begin
            if (q0.size() == 0 && i > 0) break;
            y0_ready = 1'b1;
            step();
        end
        y0_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) step();
        y0_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'(8'hC0 + i));
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        chk("pre_rst_y0_count", 32'(y0_count), 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_y0_valid", 32'(y0_valid), 32'd0);
        chk("mid_rst_y0_data", 32'(y0_data), 32'd0);
        chk("mid_rst_y0_count", 32'(y0_count), 32'd0);
        chk("mid_rst_y1_count", 32'(y1_count), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef DMUX_CHAN_BUF_STATS_EN
        chk("mid_rst_acc0", 32'(acc0_cnt), 32'd0);
`endif
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 8'($urandom));
            step();
        end
        drive(1'b0, 1'b0, 8'h00);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmux_chan_buf.md
Name: dmux_chan_buf

Overview:
- Buffered 1-to-2 stream demultiplexer. It sits directly downstream of the single-bit DMux stage and generalises it into a clocked stage.
- Accepts a WIDTH-bit word plus a select bit over a valid/ready handshake.
- Steers each word into one of two independent per-channel FIFOs: sel=0 goes to channel 0 (y0), sel=1 goes to channel 1 (y1).
- Each channel drains over its own valid/ready handshake, so a stall on one channel never blocks the other.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, entries per channel FIFO; power of two, minimum 2
CW, $clog2(DEPTH)+1, occupancy counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_sel  input  1  destination select: 0 means channel 0, 1 means channel 1
in_data  input  WIDTH  upstream word
in_ready  output  1  selected channel can accept the word
y0_valid  output  1  channel 0 head valid
y0_data  output  WIDTH  channel 0 head word
y0_ready  input  1  channel 0 consumer ready
y0_count  output  CW  channel 0 occupancy
y1_valid  output  1  channel 1 head valid
y1_data  output  WIDTH  channel 1 head word
y1_ready  input  1  channel 1 consumer ready
y1_count  output  CW  channel 1 occupancy

Behaviour:
- Reset: rst_n low asynchronously clears every output.
  - All read/write pointers and counts go to 0.
  - y0_valid=y1_valid=0; y0_data=y1_data=0; storage is cleared to 0.
  - in_ready = 1 after reset, for either sel value.
- Reset mid-operation: all buffered words are discarded; no partial transfer completes.
- in_ready is combinational: in_ready = (in_sel ? ~full1 : ~full0), where fullN = (yN_count == DEPTH).
- Push: when in_valid & in_ready at a rising edge, in_data is written at the selected channel's write pointer. That pointer increments mod DEPTH.
- Only the selected channel changes; the other channel is untouched.
- Pop: when yN_valid & yN_ready at a rising edge, channel N's read pointer increments mod DEPTH.
- yN_valid = (yN_count != 0).
- yN_data = storage[read pointer], combinational from the array; it is 0 whenever the channel is empty.
- Latency: a word pushed at edge k appears on yN_data with yN_valid=1 after edge k (one cycle). There is no bypass path from in_data to yN_data.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop on the same channel in the same cycle: unchanged, both pointers advance
- Full: in_ready=0 for that channel. A push is not accepted even if yN_ready=1 in the same cycle (no full-bypass).
- Empty: yN_ready is ignored; pointers hold.
- Wrap-around: pointers roll from DEPTH-1 to 0. Ordering within a channel is strict FIFO.
- Ordering across channels is not preserved or tracked.
- in_data and in_sel may change freely while in_valid=0.
- With in_valid=1 and in_ready=0, upstream must hold in_sel and in_data; the block samples them only on acceptance.
- Channels pop independently; simultaneous pops on both channels plus a push to either channel in one cycle is legal.

Optional Feature:
- Macro: DMUX_CHAN_BUF_STATS_EN.
- When defined, two extra outputs are added:
  - acc0_cnt [15:0] and acc1_cnt [15:0], counting accepted pushes per channel.
  - Both reset to 0 and wrap from 16'hFFFF to 0.
- Also added: stall output, registered. It is 1 for the cycle after any cycle with in_valid=1 and in_ready=0; otherwise 0. It resets to 0.
- When undefined, these ports and their logic are absent; the core behaviour is identical.

Test Plan:
- Reset, then push 8'hA5 with sel=0 → next cycle y0_valid=1, y0_data=A5, y0_count=1; y1_valid=0, y1_count=0.
- Push 4 words (01,02,03,04) with sel=1 and y1_ready=0 → y1_count=4 and in_ready=0 for sel=1, while in_ready=1 for sel=0. A 5th push is held, not lost.
- From the full-channel-1 state, assert y1_ready=1 for 6 cycles → y1_data sequence 01,02,03,04. y1_valid drops after the 4th pop; count returns to 0; pointers wrap cleanly on the next fill.
- Channel 0 holding 2 words; push to channel 0 and pop channel 0 in the same cycle → y0_count stays 2, FIFO order is preserved.
- Interleave sel 0,1,0,1 with data 10,20,30,40, y0_ready=1, y1_ready=0 → y0 emits 10,30 with no stall; y1_count=2 holding 20,40.
- Load 3 words into channel 0, then pulse rst_n low between clock edges → all outputs are immediately 0 and in_ready=1. With STATS_EN defined, acc0_cnt=0.
